uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
// - 8N1 UART receiver on the board RX pin; deserialises host bytes and hands them
//   to the core's MMIO/boot-load logic over a valid/ready byte interface.
// - Sits between the top-level RX pad and the processor-side UART register block.
// - Default timing targets 100 MHz CLK100 at 115200 baud (868 clocks/bit, 8.68 us).
// PARAMETERS
// - CLK_FREQ   100_000_000  system clock frequency in Hz
// - BAUD       115200       line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide) = 868
// - DATA_BITS  8            payload bits per frame, sent LSB first
// PORTS
// - CLK100     in   1          system clock; only clock in the block
// - RST        in   1          synchronous, active-high reset
// - RX         in   1          asynchronous serial input, idle high
// - rx_data    out  DATA_BITS  received byte; stable while rx_valid=1
// - rx_valid   out  1          byte available; held until accepted
// - rx_ready   in   1          consumer accepts byte when rx_valid & rx_ready
// - frame_err  out  1          1-cycle pulse: stop bit sampled low
// - overrun    out  1          1-cycle pulse: new frame completed while rx_valid=1
// BEHAVIOUR
// - Clock and reset: one clock, CLK100. RST is synchronous and active-high.
// - Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, FSM=IDLE,
//   2-FF RX synchroniser=1, bit counter=0, baud counter=0.
// - RX passes a 2-FF synchroniser (rx_s); all decisions use rx_s only.
// - FSM: IDLE -> START -> DATA -> STOP -> IDLE; baud counter runs 0..CLKS_PER_BIT-1.
//   IDLE: rx_s==0 -> START, baud counter cleared.
//   START: at count CLKS_PER_BIT/2-1 (434 clocks; mid start bit) re-sample rx_s.
//     - rx_s==1 -> glitch, back to IDLE, nothing reported.
//     - rx_s==0 -> DATA, baud counter cleared.
//   DATA: each full CLKS_PER_BIT, shift rx_s into bit DATA_BITS-1 of the shift
//     register (LSB first). After DATA_BITS samples -> STOP.
//   STOP: after CLKS_PER_BIT, sample rx_s, then return to IDLE on the next cycle.
//     - Stop sample 0: pulse frame_err; data discarded; rx_valid unchanged. FSM does
//       not re-arm until rx_s==1 again (break is not a start).
//     - Stop sample 1, rx_valid==0 (or accepted this cycle): rx_data<=shift register;
//       rx_valid=1 on the next cycle.
//     - Stop sample 1, rx_valid==1 and no acceptance this cycle: pulse overrun;
//       old rx_data kept; new byte dropped.
// - Handshake: rx_valid falls the cycle after rx_valid & rx_ready. Acceptance and
//   new-byte load in the same cycle -> rx_valid stays 1 with the new data (no overrun).
// - rx_ready is ignored while rx_valid=0. rx_data never changes while rx_valid=1.
// - Latency: rx_valid rises 1 cycle after the mid-stop-bit sample
//   (~9.5 bit times after the falling start edge, plus 2 synchroniser cycles).
// - RST mid-frame: the frame is aborted and the held byte is lost. RX low at reset
//   release is treated as a new start edge.
// CONFIGURATION
// - UART_RX_PARITY_EN defined:
//   - Frame becomes 8E1. PARITY state sits between DATA and STOP.
//   - Parity mismatch (XOR of data bits and parity bit != 0) pulses frame_err
//     with the stop-check timing. The byte is discarded.
// - UART_RX_PARITY_EN undefined: plain 8N1. No PARITY state or logic is generated.
// TESTING
// - Send 0x55 (RX 8680 ns/bit) after 95.68 us idle -> rx_valid=1 with rx_data=0x55.
// - Send 0x55, then 0xCE with rx_ready=1 -> two accepts, 0x55 then 0xCE; no err pulses.
// - 300 ns low glitch on idle RX -> FSM back to IDLE; no rx_valid, no frame_err.
// - Frame 0xA5 with stop bit held low -> frame_err single pulse; rx_valid stays 0;
//   the next good 0x3C is received.
// - rx_ready=0, send 0x11 then 0x22 -> overrun pulse once; rx_data=0x11 until
//   accepted; rx_valid then falls.
// - Assert RST at bit 4 of a frame, release, send 0x7E -> only 0x7E delivered.
//   With UART_RX_PARITY_EN: 0x07 with wrong parity -> frame_err, no rx_valid.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a valid/ready byte output
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check before the stop bit.
module uart_rx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK100,
  input  logic                 RST,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_q, par_err_d;
`endif

  always_ff @(posedge CLK100) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_err_d = ^{shift_q, rx_s_q};
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            // Line held low: wait for it to return high so a break is not a start.
            ferr_d  = 1'b1;
            state_d = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_err_q) begin
            ferr_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_IDLE;
            if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
